// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall control for the 5-stage pipeline.
// Optional FWD_HOLD_EN macro adds a one-entry hold register for distance-3 bypass.
`timescale 1ns/1ps

module fwd_hazard_unit #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_SRC*ADDR_W-1:0] rs_addr_id,
    input  logic [NUM_SRC*ADDR_W-1:0] rs_addr_ex,
    input  logic [NUM_SRC*XLEN-1:0]   rs_data_ex,
    input  logic [ADDR_W-1:0]         rd_ex,
    input  logic [ADDR_W-1:0]         rd_mem,
    input  logic [ADDR_W-1:0]         rd_wb,
    input  logic                      regwrite_ex,
    input  logic                      regwrite_mem,
    input  logic                      regwrite_wb,
    input  logic                      memread_ex,
    input  logic [XLEN-1:0]           alu_result_mem,
    input  logic [XLEN-1:0]           wdata_wb,
    output logic [NUM_SRC*XLEN-1:0]   fwd_data_ex,
    output logic [NUM_SRC*2-1:0]      fwd_sel_ex,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      flush_ex,
    output logic [CNT_W-1:0]          stall_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b10;
    localparam logic [1:0] SEL_WB   = 2'b01;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    // The first stall cycle is the detection cycle, so STALL covers LOAD_LAT-1 more.
    localparam int         CNT_INIT_I = (LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0;
    localparam logic [1:0] CNT_INIT   = CNT_INIT_I[1:0];

    state_t     state;
    logic [1:0] cnt;
    logic       id_match;
    logic       hazard;
    logic       stall_active;

`ifdef FWD_HOLD_EN
    logic              hold_valid;
    logic [ADDR_W-1:0] hold_rd;
    logic [XLEN-1:0]   hold_data;

    // Keeps the last WB write one extra cycle for a non write-through register file.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
        end else if (regwrite_wb && (rd_wb != '0)) begin
            hold_valid <= 1'b1;
            hold_rd    <= rd_wb;
            hold_data  <= wdata_wb;
        end else begin
            hold_valid <= 1'b0;
        end
    end
`endif

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [ADDR_W-1:0] src_addr;
        logic [XLEN-1:0]   src_data;
        logic              mem_hit;
        logic              wb_hit;
        logic [1:0]        sel;
        logic [XLEN-1:0]   data;

        assign src_addr = rs_addr_ex[g*ADDR_W +: ADDR_W];
        assign src_data = rs_data_ex[g*XLEN +: XLEN];
        assign mem_hit  = regwrite_mem && (rd_mem != '0) && (rd_mem == src_addr);
        assign wb_hit   = regwrite_wb  && (rd_wb  != '0) && (rd_wb  == src_addr);

        always_comb begin
            sel  = SEL_RF;
            data = src_data;
            if (rstn) begin
                if (mem_hit) begin
                    sel  = SEL_MEM;
                    data = alu_result_mem;
                end else if (wb_hit) begin
                    sel  = SEL_WB;
                    data = wdata_wb;
                end
`ifdef FWD_HOLD_EN
                else if (hold_valid && (hold_rd != '0) && (hold_rd == src_addr)) begin
                    sel  = SEL_HOLD;
                    data = hold_data;
                end
`endif
            end
        end

        assign fwd_sel_ex[g*2 +: 2]     = sel;
        assign fwd_data_ex[g*XLEN +: XLEN] = data;
    end

    always_comb begin
        id_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rs_addr_id[i*ADDR_W +: ADDR_W] == rd_ex) begin
                id_match = 1'b1;
            end
        end
    end

    assign hazard = memread_ex && regwrite_ex && (rd_ex != '0) && id_match;

    // Mealy in IDLE so the stall starts in the detection cycle; Moore while in STALL.
    assign stall_active = rstn && ((state == STALL) || hazard);
    assign stall_if     = stall_active;
    assign stall_id     = stall_active;
    assign flush_ex     = stall_active;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state <= STALL;
                        cnt   <= CNT_INIT;
                    end
                end
                STALL: begin
                    if (cnt == 2'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (stall_id && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding vector table plus load-use,
// saturation and reset-abort sequences; a LOAD_LAT=1 instance shares the stimulus.
`timescale 1ns/1ps

module tb_fwd_hazard_unit;

    logic        clk;
    logic        rstn;
    logic [9:0]  rs_addr_id;
    logic [9:0]  rs_addr_ex;
    logic [63:0] rs_data_ex;
    logic [4:0]  rd_ex;
    logic [4:0]  rd_mem;
    logic [4:0]  rd_wb;
    logic        regwrite_ex;
    logic        regwrite_mem;
    logic        regwrite_wb;
    logic        memread_ex;
    logic [31:0] alu_result_mem;
    logic [31:0] wdata_wb;

    logic [63:0] fwd_data_ex;
    logic [3:0]  fwd_sel_ex;
    logic        stall_if;
    logic        stall_id;
    logic        flush_ex;
    logic [3:0]  stall_cnt;

    logic [63:0] fwd_data_1;
    logic [3:0]  fwd_sel_1;
    logic        stall_if_1;
    logic        stall_id_1;
    logic        flush_1;
    logic [3:0]  stall_cnt_1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]  rs_ex;
        logic [63:0] rs_data;
        logic [4:0]  rd_mem;
        logic [4:0]  rd_wb;
        logic        rw_mem;
        logic        rw_wb;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [3:0]  exp_sel;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[7];

`ifdef FWD_HOLD_EN
    localparam logic [3:0]  HOLD_SEL  = 4'b0011;
    localparam logic [63:0] HOLD_DATA = {32'h22, 32'h55};
`else
    localparam logic [3:0]  HOLD_SEL  = 4'b0000;
    localparam logic [63:0] HOLD_DATA = {32'h22, 32'h99};
`endif

    fwd_hazard_unit #(
        .XLEN(32), .ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(4)
    ) u_dut (
        .clk(clk), .rstn(rstn),
        .rs_addr_id(rs_addr_id), .rs_addr_ex(rs_addr_ex), .rs_data_ex(rs_data_ex),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .memread_ex(memread_ex), .alu_result_mem(alu_result_mem), .wdata_wb(wdata_wb),
        .fwd_data_ex(fwd_data_ex), .fwd_sel_ex(fwd_sel_ex),
        .stall_if(stall_if), .stall_id(stall_id), .flush_ex(flush_ex),
        .stall_cnt(stall_cnt)
    );

    fwd_hazard_unit #(
        .XLEN(32), .ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(4)
    ) u_dut1 (
        .clk(clk), .rstn(rstn),
        .rs_addr_id(rs_addr_id), .rs_addr_ex(rs_addr_ex), .rs_data_ex(rs_data_ex),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .memread_ex(memread_ex), .alu_result_mem(alu_result_mem), .wdata_wb(wdata_wb),
        .fwd_data_ex(fwd_data_1), .fwd_sel_ex(fwd_sel_1),
        .stall_if(stall_if_1), .stall_id(stall_id_1), .flush_ex(flush_1),
        .stall_cnt(stall_cnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [4:0] src1, input logic [4:0] src0,
                                   input logic [31:0] d1, input logic [31:0] d0,
                                   input logic [4:0] rdm, input logic rwm,
                                   input logic [4:0] rdw, input logic rww,
                                   input logic [31:0] alu, input logic [31:0] wd,
                                   input logic [3:0] esel,
                                   input logic [31:0] e1, input logic [31:0] e0);
        vec_t v;
        v.rs_ex    = {src1, src0};
        v.rs_data  = {d1, d0};
        v.rd_mem   = rdm;
        v.rw_mem   = rwm;
        v.rd_wb    = rdw;
        v.rw_wb    = rww;
        v.alu      = alu;
        v.wdata    = wd;
        v.exp_sel  = esel;
        v.exp_data = {e1, e0};
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rs_addr_ex     = v.rs_ex;
        rs_data_ex     = v.rs_data;
        rd_mem         = v.rd_mem;
        regwrite_mem   = v.rw_mem;
        rd_wb          = v.rd_wb;
        regwrite_wb    = v.rw_wb;
        alu_result_mem = v.alu;
        wdata_wb       = v.wdata;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        rs_addr_id     = '0;
        rs_addr_ex     = '0;
        rs_data_ex     = '0;
        rd_ex          = '0;
        rd_mem         = '0;
        rd_wb          = '0;
        regwrite_ex    = 1'b0;
        regwrite_mem   = 1'b0;
        regwrite_wb    = 1'b0;
        memread_ex     = 1'b0;
        alu_result_mem = '0;
        wdata_wb       = '0;
    endtask

    initial begin
        vecs[0] = mkVec(5'd9, 5'd5, 32'h1111_1111, 32'h2222_2222, 5'd5, 1'b1, 5'd5, 1'b1,
                        32'hAAAA, 32'hBBBB, 4'b0010, 32'h1111_1111, 32'hAAAA);
        vecs[1] = mkVec(5'd0, 5'd6, 32'h1234, 32'h6666, 5'd0, 1'b1, 5'd3, 1'b0,
                        32'hDEAD, 32'hBEEF, 4'b0000, 32'h1234, 32'h6666);
        vecs[2] = mkVec(5'd8, 5'd6, 32'h8888, 32'h6666, 5'd8, 1'b1, 5'd6, 1'b1,
                        32'hA1, 32'hB2, 4'b1001, 32'hA1, 32'hB2);
        vecs[3] = mkVec(5'd7, 5'd7, 32'h77, 32'h70, 5'd7, 1'b0, 5'd7, 1'b1,
                        32'hA3, 32'hB3, 4'b0101, 32'hB3, 32'hB3);
        vecs[4] = mkVec(5'd2, 5'd7, 32'h22, 32'h71, 5'd7, 1'b0, 5'd7, 1'b0,
                        32'hA4, 32'hB4, 4'b0000, 32'h22, 32'h71);
        vecs[5] = mkVec(5'd0, 5'd0, 32'hF0, 32'h0F, 5'd0, 1'b1, 5'd0, 1'b1,
                        32'hA5, 32'hB5, 4'b0000, 32'hF0, 32'h0F);
        vecs[6] = mkVec(5'd3, 5'd3, 32'h1, 32'h2, 5'd3, 1'b1, 5'd3, 1'b1,
                        32'hC5, 32'hD6, 4'b1010, 32'hC5, 32'hC5);

        // Reset: forwarding and stall outputs are suppressed even with matches present.
        clearInputs();
        rstn = 1'b0;
        tick();
        tick();
        rd_mem         = 5'd5;
        regwrite_mem   = 1'b1;
        alu_result_mem = 32'hAAAA;
        rs_addr_ex     = {5'd1, 5'd5};
        rs_data_ex     = {32'h0BAD, 32'hC0DE};
        memread_ex     = 1'b1;
        regwrite_ex    = 1'b1;
        rd_ex          = 5'd4;
        rs_addr_id     = {5'd0, 5'd4};
        @(negedge clk);
        checkOutput("reset_sel", 64'(fwd_sel_ex), 64'h0);
        checkOutput("reset_data", fwd_data_ex, {32'h0BAD, 32'hC0DE});
        checkOutput("reset_stall", 64'({stall_if, stall_id, flush_ex}), 64'h0);
        checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'h0);
        tick();
        clearInputs();
        rstn = 1'b1;

        // Forwarding table; regwrite_wb drops before each edge so the hold entry never lingers.
        for (int i = 0; i < 7; i++) begin
            tick();
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_sel", i), 64'(fwd_sel_ex), 64'(vecs[i].exp_sel));
            checkOutput($sformatf("vec%0d_data", i), fwd_data_ex, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_sel_lat1", i), 64'(fwd_sel_1), 64'(vecs[i].exp_sel));
            checkOutput($sformatf("vec%0d_data_lat1", i), fwd_data_1, vecs[i].exp_data);
            regwrite_wb = 1'b0;
        end

        // Hold path: WB writes x7 then the next cycle reads x7 with no MEM/WB match.
        tick();
        clearInputs();
        rd_wb       = 5'd7;
        regwrite_wb = 1'b1;
        wdata_wb    = 32'h55;
        rs_addr_ex  = {5'd2, 5'd1};
        rs_data_ex  = {32'h22, 32'h99};
        tick();
        regwrite_wb = 1'b0;
        rd_wb       = 5'd0;
        wdata_wb    = 32'h0;
        rs_addr_ex  = {5'd2, 5'd7};
        @(negedge clk);
        checkOutput("hold_sel", 64'(fwd_sel_ex), 64'(HOLD_SEL));
        checkOutput("hold_data", fwd_data_ex, HOLD_DATA);
        tick();
        @(negedge clk);
        checkOutput("hold_expired_sel", 64'(fwd_sel_ex), 64'h0);
        checkOutput("hold_expired_data", fwd_data_ex, {32'h22, 32'h99});

        // Load-use on source 1: three stall cycles, one for the LOAD_LAT=1 instance.
        tick();
        clearInputs();
        memread_ex  = 1'b1;
        regwrite_ex = 1'b1;
        rd_ex       = 5'd4;
        rs_addr_id  = {5'd4, 5'd1};
        @(negedge clk);
        checkOutput("lu_cycle1", 64'({stall_if, stall_id, flush_ex}), 64'h7);
        checkOutput("lu_cycle1_lat1", 64'({stall_if_1, stall_id_1, flush_1}), 64'h7);
        tick();
        memread_ex = 1'b0;
        @(negedge clk);
        checkOutput("lu_cycle2", 64'({stall_if, stall_id, flush_ex}), 64'h7);
        checkOutput("lu_cycle2_lat1", 64'({stall_if_1, stall_id_1, flush_1}), 64'h0);
        tick();
        @(negedge clk);
        checkOutput("lu_cycle3", 64'({stall_if, stall_id, flush_ex}), 64'h7);
        tick();
        @(negedge clk);
        checkOutput("lu_after", 64'({stall_if, stall_id, flush_ex}), 64'h0);
        checkOutput("lu_stall_cnt", 64'(stall_cnt), 64'd3);
        checkOutput("lu_stall_cnt_lat1", 64'(stall_cnt_1), 64'd1);

        // Hazard held on both sources for 20 cycles: continuous stall, counter saturates.
        tick();
        memread_ex = 1'b1;
        rs_addr_id = {5'd4, 5'd4};
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput($sformatf("sat_stall%0d", k), 64'({stall_if, stall_id, flush_ex}), 64'h7);
            checkOutput($sformatf("sat_cnt%0d", k), 64'(stall_cnt), 64'((3 + k > 15) ? 15 : 3 + k));
            tick();
        end
        memread_ex = 1'b0;
        checkOutput("sat_final", 64'(stall_cnt), 64'd15);
        checkOutput("sat_final_lat1", 64'(stall_cnt_1), 64'd15);
        tick();
        tick();
        tick();
        @(negedge clk);
        checkOutput("sat_drained", 64'({stall_if, stall_id, flush_ex}), 64'h0);

        // Reset in the second stall cycle aborts the sequence.
        tick();
        memread_ex = 1'b1;
        @(negedge clk);
        checkOutput("rst_stall1", 64'({stall_if, stall_id, flush_ex}), 64'h7);
        tick();
        memread_ex = 1'b0;
        @(negedge clk);
        checkOutput("rst_stall2", 64'({stall_if, stall_id, flush_ex}), 64'h7);
        rstn = 1'b0;
        #1;
        checkOutput("rst_low_outputs", 64'({stall_if, stall_id, flush_ex}), 64'h0);
        tick();
        @(negedge clk);
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("rst_aborted", 64'({stall_if, stall_id, flush_ex}), 64'h0);
        checkOutput("rst_cnt_after", 64'(stall_cnt), 64'h0);
        tick();
        @(negedge clk);
        checkOutput("rst_idle", 64'({stall_if, stall_id, flush_ex}), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the 5-stage pipeline. It detects RAW hazards and muxes the bypassed operand data for NUM_SRC EX-stage sources. It also runs a multi-cycle load-use stall FSM sized by LOAD_LAT and keeps a saturating stall-cycle counter. It sits beside the ID/EX register, driving the EX operand muxes and the IF/ID stall and EX flush controls.

## Interface
Parameters:
- XLEN, 32, operand data width
- ADDR_W, 5, register address width
- NUM_SRC, 2, number of EX source operands (1..4)
- LOAD_LAT, 1, total load-use stall cycles (1..4)
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- rs_addr_id  in  NUM_SRC*ADDR_W  source addresses of instruction in ID
- rs_addr_ex  in  NUM_SRC*ADDR_W  source addresses of instruction in EX
- rs_data_ex  in  NUM_SRC*XLEN  register-file values latched in ID/EX
- rd_ex, rd_mem, rd_wb  in  ADDR_W each  destination addresses per stage
- regwrite_ex, regwrite_mem, regwrite_wb  in  1 each  write enables per stage
- memread_ex  in  1  EX instruction is a load
- alu_result_mem  in  XLEN  MEM-stage result
- wdata_wb  in  XLEN  WB-stage write data
- fwd_data_ex  out  NUM_SRC*XLEN  forwarded operands, slice i for source i
- fwd_sel_ex  out  NUM_SRC*2  per-source select: 00 regfile, 10 MEM, 01 WB, 11 HOLD
- stall_if, stall_id  out  1 each  freeze PC and IF/ID
- flush_ex  out  1  insert bubble into ID/EX
- stall_cnt  out  CNT_W  cycles with stall_id high, saturating

## Operation
- Each source i selects data with priority MEM > WB > HOLD > regfile.
  - MEM: regwrite_mem && rd_mem!=0 && rd_mem==rs_addr_ex[i].
  - WB: same test against rd_wb/regwrite_wb.
  - HOLD: hold_valid && hold_rd!=0 && hold_rd==rs_addr_ex[i].
- Address 0 is never forwarded; sel stays 00 and data passes rs_data_ex.
- Hold register {hold_valid, hold_rd, hold_data}:
  - Captures rd_wb/wdata_wb on every edge with regwrite_wb && rd_wb!=0.
  - On any other edge, hold_valid clears.
  - Covers distance-3 dependencies when the register file is not write-through.
- Load-use FSM, states IDLE and STALL.
  - Hazard condition: memread_ex && regwrite_ex && rd_ex!=0 && rd_ex equals any rs_addr_id slice.
  - IDLE, hazard true: assert stall_if, stall_id, flush_ex in the same cycle (Mealy). If LOAD_LAT>1, load cnt=LOAD_LAT-2 and go to STALL; otherwise stay in IDLE.
  - STALL: assert all three outputs (Moore). If cnt==0, go to IDLE; else decrement cnt. Hazard detection is ignored while in STALL.
- stall_cnt increments on each edge where stall_id==1 and saturates at all-ones, with no wrap.

## Timing
- Forwarding select and data are combinational: zero-cycle latency from stage inputs.
- Hold register data is visible one cycle after the WB write.
- A load-use hazard produces exactly LOAD_LAT consecutive cycles of stall_if, stall_id and flush_ex, starting in the detection cycle.
- Reset: rstn low at an edge forces state IDLE, cnt 0, hold_valid 0, stall_cnt 0.
  - While rstn is low, stall_if, stall_id, flush_ex are 0, fwd_sel_ex is all 00, and fwd_data_ex equals rs_data_ex.
  - Reset asserted mid-STALL aborts the stall at the next edge.
- A simultaneous MEM and WB match on one source selects MEM. Multiple sources may select independently in the same cycle.
- A hazard on several ID sources still yields a single stall sequence.

## Configuration
- FWD_HOLD_EN defined: hold register is present and select 11 is reachable.
- FWD_HOLD_EN undefined: no hold register, select 11 is never produced, and the priority is MEM > WB > regfile. All other behaviour is identical.

## Test plan
- MEM/WB priority: rd_mem=rd_wb=5, both regwrite high, rs_addr_ex[0]=5, alu_result_mem=0xAAAA, wdata_wb=0xBBBB -> sel 10, data 0xAAAA.
- x0 guard: rd_mem=0, regwrite_mem=1, rs_addr_ex[1]=0, rs_data_ex[1]=0x1234 -> sel 00, data 0x1234.
- Hold path (FWD_HOLD_EN): WB writes x7=0x55 in cycle n; in n+1 rs_addr_ex[0]=7 with no MEM/WB match -> sel 11, data 0x55. Without FWD_HOLD_EN -> sel 00.
- Load-use, LOAD_LAT=3: memread_ex=1, rd_ex=4, rs_addr_id[1]=4 -> stall_if, stall_id, flush_ex high for exactly 3 cycles, then low; stall_cnt +3.
- Reset mid-stall: LOAD_LAT=4, drop rstn in the second stall cycle -> outputs 0 from the next edge, state IDLE, stall_cnt 0.
- Counter saturation: CNT_W=4, hold the hazard repeatedly for 20 stall cycles -> stall_cnt stays at 15.
